// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encodings and the queued command record layout
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [OP_W-1:0] ALU_NOT = 3'b101;
    localparam logic [OP_W-1:0] ALU_SHL = 3'b110;
    localparam logic [OP_W-1:0] ALU_SHR = 3'b111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty
module sync_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & !full_o;
    assign do_pop  = pop_i & !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    // storage needs no reset; only written slots are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: queues ALU commands, drives the head onto an external ALU and registers its result
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_carry,
    output logic              out_zero,
    output logic [OP_W-1:0]   out_op,
    output logic [CW-1:0]     count,
    output logic [15:0]       done_cnt
);

    cmd_t              head;
    logic              full, empty, push, cap;
    logic              out_valid_q, out_carry_q, out_zero_q;
    logic [DATA_W-1:0] out_y_q;
    logic [OP_W-1:0]   out_op_q;
    logic [15:0]       done_cnt_q;

    assign in_ready = rst_n & !full;
    assign push     = in_valid & in_ready;
    assign cap      = !empty & (!out_valid_q | out_ready);

    assign alu_a = empty ? '0 : head.a;
    assign alu_b = empty ? '0 : head.b;
    assign alu_s = empty ? '0 : head.op;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (cap),
        .wdata_i ({in_op, in_a, in_b}),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // result register: capture pops the head, a taken result with nothing behind it clears valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_op_q    <= '0;
        end else if (cap) begin
            out_valid_q <= 1'b1;
            out_y_q     <= alu_y;
            out_carry_q <= alu_carry;
            out_zero_q  <= alu_y == '0;
            out_op_q    <= head.op;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // delivered-result counter, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) done_cnt_q <= '0;
        else if (out_valid_q & out_ready & (done_cnt_q != 16'hFFFF)) done_cnt_q <= done_cnt_q + 16'd1;
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_carry = out_carry_q;
    assign out_zero  = out_zero_q;
    assign out_op    = out_op_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed table-driven bench for alu_issue_queue with a behavioural ALU
module tb_alu_issue_queue;
    import alu_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       c;
        logic       z;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0, in_b = '0;
    logic [2:0] in_op = '0;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_s;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic       out_carry, out_zero;
    logic [2:0] out_op;
    logic [2:0] count;
    logic [15:0] done_cnt;

    vec_t tab [16];
    int   exp_q [$];
    int   checks = 0, failures = 0;
    int   cyc = 0, n_del = 0, first_del = 0, last_del = 0;
    logic acc;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_carry(out_carry), .out_zero(out_zero), .out_op(out_op),
        .count(count), .done_cnt(done_cnt)
    );

    // behavioural ALU: carry is carry-out for ADD, borrow for SUB, zero otherwise
    always_comb begin
        {alu_carry, alu_y} = 9'h0;
        case (alu_s)
            ALU_ADD: {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB: {alu_carry, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_XOR: alu_y = alu_a ^ alu_b;
            ALU_NOT: alu_y = ~alu_a;
            ALU_SHL: alu_y = alu_a << 1;
            default: alu_y = alu_a >> 1;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock: drive at negedge, score any result taken at the coming edge, then wait for the edge
    task automatic step(input logic v, input int idx, input logic rdy, output logic a);
        int e;
        @(negedge clk);
        in_valid  = v;
        in_op     = tab[idx].op;
        in_a      = tab[idx].a;
        in_b      = tab[idx].b;
        out_ready = rdy;
        a = v & in_ready;
        if (out_valid & rdy) begin
            if (exp_q.size() == 0) chk("stale_result", {31'd0, out_valid}, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk($sformatf("y[%0d]", e), {24'd0, out_y}, {24'd0, tab[e].y});
                chk($sformatf("carry[%0d]", e), {31'd0, out_carry}, {31'd0, tab[e].c});
                chk($sformatf("zero[%0d]", e), {31'd0, out_zero}, {31'd0, tab[e].z});
                chk($sformatf("op[%0d]", e), {29'd0, out_op}, {29'd0, tab[e].op});
                n_del++;
                if (n_del == 1) first_del = cyc;
                last_del = cyc;
            end
        end
        if (a) exp_q.push_back(idx);
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, 0, 1'b1, acc);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        tab[0]  = '{ALU_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        tab[1]  = '{ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
        tab[2]  = '{ALU_SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        tab[3]  = '{ALU_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
        tab[4]  = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        tab[5]  = '{ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        tab[6]  = '{ALU_AND, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1};
        tab[7]  = '{ALU_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
        tab[8]  = '{ALU_OR,  8'h12, 8'h40, 8'h52, 1'b0, 1'b0};
        tab[9]  = '{ALU_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        tab[10] = '{ALU_XOR, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        tab[11] = '{ALU_NOT, 8'h0F, 8'h33, 8'hF0, 1'b0, 1'b0};
        tab[12] = '{ALU_NOT, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1};
        tab[13] = '{ALU_SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0};
        tab[14] = '{ALU_SHR, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0};
        tab[15] = '{ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_done_cnt", {16'd0, done_cnt}, 0);
        chk("rst_out_y", {24'd0, out_y}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 1);

        // every vector alone: accept at E0, capture at E1, valid after E1
        n_del = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, 1'b1, acc);
            #1;
            chk("lat_e0_valid", {31'd0, out_valid}, 0);
            chk("lat_e0_count", {29'd0, count}, 1);
            step(1'b0, 0, 1'b1, acc);
            #1;
            chk("lat_e1_valid", {31'd0, out_valid}, 1);
            step(1'b0, 0, 1'b1, acc);
        end
        #1;
        chk("single_ndel", n_del, 16);
        chk("single_done", {16'd0, done_cnt}, 16);

        // backpressure: 5 of 6 accepted, then release in order
        n_del = 0;
        for (int i = 0; i < 5; i++) step(1'b1, i, 1'b0, acc);
        #1;
        chk("full_count", {29'd0, count}, 4);
        chk("full_in_ready", {31'd0, in_ready}, 0);
        chk("full_out_valid", {31'd0, out_valid}, 1);
        chk("full_hold_y", {24'd0, out_y}, {24'd0, tab[0].y});
        step(1'b1, 5, 1'b0, acc);
        chk("full_reject", {31'd0, acc}, 0);
        #1;
        chk("full_count2", {29'd0, count}, 4);
        drain();
        chk("full_ndel", n_del, 5);
        #1;
        chk("full_done", {16'd0, done_cnt}, 21);

        // simultaneous push and pop at count=2
        for (int i = 6; i < 9; i++) step(1'b1, i, 1'b0, acc);
        #1;
        chk("pp_count_pre", {29'd0, count}, 2);
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 9 + j, 1'b1, acc);
            #1;
            chk("pp_count", {29'd0, count}, 2);
        end
        drain();

        // reset with queued and in-flight work
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, acc);
        #1;
        chk("prerst_count", {29'd0, count}, 3);
        chk("prerst_valid", {31'd0, out_valid}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("inrst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk);
        cyc++;
        #1;
        chk("postrst_valid", {31'd0, out_valid}, 0);
        chk("postrst_count", {29'd0, count}, 0);
        chk("postrst_done", {16'd0, done_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, acc);
        #1;
        chk("postrst_idle_valid", {31'd0, out_valid}, 0);

        // stream all vectors back to back
        begin
            int pi = 0;
            n_del = 0;
            for (int k = 0; k < 40 && n_del < 16; k++) begin
                step(pi < 16, pi < 16 ? pi : 0, 1'b1, acc);
                if (acc) pi++;
            end
            in_valid = 1'b0;
            #1;
            chk("stream_pushed", pi, 16);
            chk("stream_ndel", n_del, 16);
            chk("stream_consecutive", last_del - first_del, 15);
            chk("stream_done", {16'd0, done_cnt}, 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
